// File: rtl/fifo_pkg.sv
// Shared types for sync_fifo_flags.
//   push_e_t / pop_e_t : 1-bit request encodings for the write and read sides.
//   data_t / DATA_RST  : default data word type and its reset value.
//   ptr_w()            : pointer/count width for a given depth (address bits + wrap bit).
package fifo_pkg;

    typedef enum logic { NO_PUSH = 1'b0, PUSH = 1'b1 } push_e_t;
    typedef enum logic { NO_POP  = 1'b0, POP  = 1'b1 } pop_e_t;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    typedef logic [DATA_W_DEF-1:0] data_t;
    localparam data_t DATA_RST = '0;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_if.sv
// Bundle of FIFO request and status signals.
//   master : producer/consumer side (drives push, data_in, pop, clr_err).
//   slave  : FIFO side (drives data, flags, count, sticky errors).
//   fifo   : alias of slave, the storage-block view.
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    localparam int CW = ptr_w(DEPTH);

    push_e_t             push;
    logic [DATA_W-1:0]   data_in;
    logic                full;
    logic                almost_full;
    pop_e_t              pop;
    logic [DATA_W-1:0]   data_out;
    logic                empty;
    logic                almost_empty;
    logic [CW-1:0]       count;
    logic                overflow;
    logic                underflow;
    logic                clr_err;

    modport master (
        output push, data_in, pop, clr_err,
        input  full, almost_full, data_out, empty, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, data_in, pop, clr_err,
        output full, almost_full, data_out, empty, almost_empty,
               count, overflow, underflow
    );

    modport fifo (
        input  push, data_in, pop, clr_err,
        output full, almost_full, data_out, empty, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// Contents are intentionally not reset.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty,
// sticky overflow/underflow and registered or first-word-fall-through read.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : fifo_if slave view (push/data_in/pop/clr_err in; data_out, flags,
//         count, overflow, underflow out)
// All outputs come from flops or from the RAM read port addressed by a flop,
// so there is no combinational path from push/pop to any output.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic   clk,
    input  logic   rst,
    fifo_if.slave  bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic              empty_q, empty_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic              push_ok, pop_ok;
    logic [DATA_W-1:0] ram_rdata;

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        pop_ok   = (bus.pop == POP) && !empty_q;
        // At full a concurrent pop frees the slot the push writes into.
        push_ok  = (bus.push == PUSH) && (!full_q || pop_ok);

        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = wr_ptr_d - rd_ptr_d;

        full_d   = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        afull_d  = (count_d >= PW'(AFULL_TH));
        aempty_d = (count_d <= PW'(AEMPTY_TH));

        // Set beats clear when both happen in one cycle.
        ovf_d = ovf_q;
        if ((bus.push == PUSH) && !push_ok) ovf_d = 1'b1;
        else if (bus.clr_err)               ovf_d = 1'b0;

        unf_d = unf_q;
        if ((bus.pop == POP) && !pop_ok)    unf_d = 1'b1;
        else if (bus.clr_err)               unf_d = 1'b0;

        // Read data is sampled before the same-edge write, so a push+pop at
        // full returns the oldest word, not the incoming one.
        dout_d = dout_q;
        if (pop_ok) dout_d = ram_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
        end
    end

    // FWFT shows the head word straight off the RAM; with no valid head it
    // shows zero so stale memory never leaks out (including after reset).
    assign bus.data_out     = FWFT ? (empty_q ? '0 : ram_rdata) : dout_q;
    assign bus.full         = full_q;
    assign bus.almost_full  = afull_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;
    import fifo_pkg::*;

    localparam int DW = 8;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_if #(.DATA_W(DW), .DEPTH(DP)) b0 ();
    fifo_if #(.DATA_W(DW), .DEPTH(DP)) b1 ();

    sync_fifo_flags #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1'b0))
        u_reg (.clk(clk), .rst(rst), .bus(b0));
    sync_fifo_flags #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1'b1))
        u_fwft (.clk(clk), .rst(rst), .bus(b1));

    // Reference model: queue of stored words plus sticky bits and registered read word.
    logic [7:0] mq[$];
    logic       m_ovf, m_unf;
    logic [7:0] m_dout0;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [35:0] exp_vec();
        int n;
        logic [7:0] head;
        n = mq.size();
        head = (n > 0) ? mq[0] : 8'h00;
        return {n == 8, n >= 6, n == 0, n <= 2, 4'(n), m_ovf, m_unf, m_dout0,
                n == 8, n >= 6, n == 0, n <= 2, 4'(n), m_ovf, m_unf, head};
    endfunction

    function automatic logic [35:0] obs_vec();
        return {b0.full, b0.almost_full, b0.empty, b0.almost_empty, b0.count,
                b0.overflow, b0.underflow, b0.data_out,
                b1.full, b1.almost_full, b1.empty, b1.almost_empty, b1.count,
                b1.overflow, b1.underflow, b1.data_out};
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_dout0 = 8'h00;
    endfunction

    // One clock: drive inputs, step the model, land #1 after the edge.
    task automatic cycle(input bit p, input logic [7:0] d, input bit o, input bit c);
        bit pop_ok, push_ok;
        b0.push = p ? PUSH : NO_PUSH;  b1.push = p ? PUSH : NO_PUSH;
        b0.pop  = o ? POP : NO_POP;    b1.pop  = o ? POP : NO_POP;
        b0.data_in = d;  b1.data_in = d;
        b0.clr_err = c;  b1.clr_err = c;
        @(posedge clk);
        pop_ok  = o && (mq.size() > 0);
        push_ok = p && ((mq.size() < DP) || pop_ok);
        if (pop_ok) m_dout0 = mq.pop_front();
        if (push_ok) mq.push_back(d);
        if (p && !push_ok) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (o && !pop_ok)  m_unf = 1'b1; else if (c) m_unf = 1'b0;
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (mq.size() > 0 && guard < 20) begin
            cycle(0, 8'h00, 1, 0);
            guard++;
        end
    endtask

    task automatic test_reset();
        b0.push = NO_PUSH; b1.push = NO_PUSH; b0.pop = NO_POP; b1.pop = NO_POP;
        b0.data_in = '0; b1.data_in = '0; b0.clr_err = 0; b1.clr_err = 0;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_vec() !== 36'({1'b0,1'b0,1'b1,1'b1,4'd0,1'b0,1'b0,8'h00,
                               1'b0,1'b0,1'b1,1'b1,4'd0,1'b0,1'b0,8'h00})) begin
            n_err++;
            $display("FAIL reset_state: got %h want reset values", obs_vec());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h40 + i), 0, 0);
        n_cmp++;
        if (b0.count !== 4'd5) begin
            n_err++; $display("FAIL pre_reset_count: got %0d want 5", b0.count);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({b0.count, b0.empty, b0.almost_empty, b1.count, b1.empty, b1.data_out}
                !== {4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL async_reset: got cnt=%0d e=%b ae=%b fw_cnt=%0d fw_e=%b fw_do=%h",
                     b0.count, b0.empty, b0.almost_empty, b1.count, b1.empty, b1.data_out);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_fill_wrap();
        logic [7:0] e1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                cycle(1, 8'(8'h10 + i), 0, 0);
                n_cmp++;
                if ({b0.count, b0.almost_full, b0.full} !== {4'(i + 1), (i + 1) >= 6, i == 7}) begin
                    n_err++;
                    $display("FAIL fill_flags r%0d i%0d: got cnt=%0d af=%b f=%b", r, i,
                             b0.count, b0.almost_full, b0.full);
                end
            end
            for (int i = 0; i < 8; i++) begin
                cycle(0, 8'h00, 1, 0);
                e1 = (i < 7) ? 8'(8'h11 + i) : 8'h00;
                n_cmp++;
                if ({b0.data_out, b0.count, b1.data_out} !== {8'(8'h10 + i), 4'(7 - i), e1}) begin
                    n_err++;
                    $display("FAIL drain_order r%0d i%0d: got do=%h cnt=%0d fw=%h want %h %0d %h",
                             r, i, b0.data_out, b0.count, b1.data_out, 8'(8'h10 + i), 7 - i, e1);
                end
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) cycle(1, 8'(8'h20 + i), 0, 0);
        cycle(1, 8'hAA, 0, 0);
        n_cmp++;
        if ({b0.count, b0.overflow, b0.full} !== {4'd8, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL overflow_set: got cnt=%0d ovf=%b full=%b", b0.count, b0.overflow, b0.full);
        end
        cycle(0, 8'h00, 0, 0);
        n_cmp++;
        if (b0.overflow !== 1'b1) begin
            n_err++; $display("FAIL overflow_hold: got %b want 1", b0.overflow);
        end
        cycle(0, 8'h00, 0, 1);
        n_cmp++;
        if (b0.overflow !== 1'b0) begin
            n_err++; $display("FAIL overflow_clr: got %b want 0", b0.overflow);
        end
        cycle(1, 8'hBB, 1, 0);
        n_cmp++;
        if ({b0.count, b0.data_out, b1.data_out, b0.overflow} !== {4'd8, 8'h20, 8'h21, 1'b0}) begin
            n_err++;
            $display("FAIL full_push_pop: got cnt=%0d do=%h fw=%h ovf=%b want 8 20 21 0",
                     b0.count, b0.data_out, b1.data_out, b0.overflow);
        end
        drain();
        n_cmp++;
        if ({b0.data_out, b0.empty} !== {8'hBB, 1'b1}) begin
            n_err++; $display("FAIL full_tail_word: got do=%h e=%b want bb 1", b0.data_out, b0.empty);
        end
    endtask

    task automatic test_empty_push_pop();
        cycle(1, 8'h3C, 1, 0);
        n_cmp++;
        if ({b0.count, b0.underflow, b0.empty, b1.data_out} !== {4'd1, 1'b1, 1'b0, 8'h3C}) begin
            n_err++;
            $display("FAIL empty_push_pop: got cnt=%0d unf=%b e=%b fw=%h want 1 1 0 3c",
                     b0.count, b0.underflow, b0.empty, b1.data_out);
        end
        cycle(0, 8'h00, 0, 1);
        drain();
    endtask

    task automatic test_fwft();
        cycle(1, 8'h55, 0, 0);
        n_cmp++;
        if ({b1.data_out, b1.empty} !== {8'h55, 1'b0}) begin
            n_err++; $display("FAIL fwft_visible: got do=%h e=%b want 55 0", b1.data_out, b1.empty);
        end
        cycle(0, 8'h00, 1, 0);
        n_cmp++;
        if ({b1.empty, b0.data_out} !== {1'b1, 8'h55}) begin
            n_err++; $display("FAIL fwft_pop: got e=%b reg_do=%h want 1 55", b1.empty, b0.data_out);
        end
    endtask

    task automatic test_clr_vs_underflow();
        cycle(0, 8'h00, 1, 1);
        n_cmp++;
        if ({b0.underflow, b1.underflow} !== 2'b11) begin
            n_err++; $display("FAIL clr_vs_unf: got %b%b want 11", b0.underflow, b1.underflow);
        end
        cycle(0, 8'h00, 0, 1);
        n_cmp++;
        if (b0.underflow !== 1'b0) begin
            n_err++; $display("FAIL unf_clear: got %b want 0", b0.underflow);
        end
    endtask

    task automatic test_random();
        bit p, o, c;
        for (int i = 0; i < 600; i++) begin
            p = ($urandom_range(0, 99) < 55);
            o = ($urandom_range(0, 99) < 45 + ((i / 150) % 2) * 20);
            c = ($urandom_range(0, 15) == 0);
            cycle(p, 8'($urandom), o, c);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random_cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_fill_wrap();
        test_overflow();
        test_empty_push_pop();
        test_fwft();
        test_clr_vs_underflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
